blocking_reg_pair: RTL and testbench
====================================

// Module: blocking_reg_pair
//
// PURPOSE
//   Single-stage register pair demonstrating blocking-assignment semantics.
//   On each rising clk edge, input a is captured into b, and c is loaded
//   from the freshly updated b. Both outputs therefore hold the same sample
//   of a, one cycle after capture; c is never a second pipeline stage.
//   Teaching/reference block, paired with a non-blocking two-stage variant.
//
// PARAMETERS
//   WIDTH  4  data width of a, b and c, in bits (>=1)
//
// PORTS
//   clk  input   1      rising-edge clock
//   rst  input   1      asynchronous reset, active-high
//   a    input   WIDTH  data sample to capture
//   b    output  WIDTH  registered copy of a
//   c    output  WIDTH  registered copy of b's new value (equals b)
//
// BEHAVIOUR
//   - One clock (clk), rising edge. Asynchronous active-high reset (rst).
//   - rst=1: b and c clear to 0 immediately, independent of clk.
//     They hold 0 while rst=1.
//   - rst deasserted: the first capture occurs on the next rising clk edge.
//   - Each rising edge with rst=0: b_next = a; c_next = b_next (= a).
//     Equivalent to the sequential blocking pair b = a; c = b;
//   - Latency: a -> b is 1 cycle; a -> c is 1 cycle (not 2).
//   - Invariant: b == c at all times outside the reset transition.
//   - Outputs are pure registers. There is no combinational path from a
//     to b or c.
//   - a changing between edges has no effect until the next rising edge.
//   - rst asserted mid-operation clears both outputs in the same instant.
//     No partial update is allowed (b and c never differ).
//   - Width rule: all WIDTH bits are copied unchanged. No arithmetic,
//     no extension, no truncation.
//   - No enable, no handshake. Every edge captures.
//
// TESTING  (clk period 100 ns, first rising edge at 50 ns, a driven at 0/100/200/...)
//   1. Reset: rst=1, a=4'h3, clk toggling -> b=c=4'h0. Then rst=0 before
//      the 50 ns edge -> b=c=4'h3 after the 50 ns edge.
//   2. Sequence: a = 3, 7, F, A, 2 at 0, 100, 200, 300, 400 ns -> b=c =
//      3, 7, F, A, 2 after the edges at 50, 150, 250, 350, 450 ns. c must
//      never lag b by a cycle.
//   3. Mid-cycle change: a = 5 then 9 between two edges -> only 9 is
//      captured. b/c remain unchanged until that edge.
//   4. Async reset mid-run: b=c=F, assert rst at a falling-edge time ->
//      b=c=0 immediately, without waiting for a clk edge. Hold rst over
//      two edges -> outputs stay 0.
//   5. Invariant check: random a over 100 cycles -> b==c and
//      b==a(previous edge) every cycle. Also check WIDTH=8 with a=8'hA5
//      -> b=c=8'hA5.

Source files
------------

// File: rtl/blocking_reg_pair.sv
// Register pair showing blocking-assignment semantics: b and c both capture
// the same sample of a on each rising clk edge, so c always equals b and is
// never a second pipeline stage. Paired with a non-blocking two-stage variant.
module blocking_reg_pair #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c
);

    // Capture a into b, and load c from b's new value (which is a) in the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b <= '0;
            c <= '0;
        end else begin
            b <= a;
            c <= a;
        end
    end

endmodule

// File: tb/tb_blocking_reg_pair.sv
// Scoreboard bench for blocking_reg_pair: checks a WIDTH=4 and a WIDTH=8
// instance against hand-computed expected values queued by the stimulus.
module tb_blocking_reg_pair;

    typedef struct {
        logic [3:0] e4;
        logic [7:0] e8;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a4  = '0;
    logic [7:0] a8  = '0;
    logic [3:0] b4, c4;
    logic [7:0] b8, c8;

    exp_t  sb[$];
    event  chk_ev;
    int    n_cmp  = 0;
    int    n_fail = 0;

    blocking_reg_pair #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .a   (a4),
        .b   (b4),
        .c   (c4)
    );

    blocking_reg_pair #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .a   (a8),
        .b   (b8),
        .c   (c8)
    );

    // Period 100 ns, first rising edge at 50 ns.
    always #50 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    // Monitor: after every rising edge or requested async check, pop one
    // expected entry (if queued) and compare both instances.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".b4"}, {4'h0, b4}, {4'h0, e.e4});
                check({e.name, ".c4"}, {4'h0, c4}, {4'h0, e.e4});
                check({e.name, ".b8"}, b8, e.e8);
                check({e.name, ".c8"}, c8, e.e8);
            end
        end
    end

    task automatic push(input logic [3:0] e4, input logic [7:0] e8, input string nm);
        exp_t e;
        e.e4   = e4;
        e.e8   = e8;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Check the current outputs without waiting for a clock edge.
    task automatic async_check(input logic [3:0] e4, input logic [7:0] e8, input string nm);
        push(e4, e8, nm);
        -> chk_ev;
        #5;
    endtask

    // Drive a at the falling edge and expect it on both outputs after the next rising edge.
    task automatic step(input logic [3:0] v4, input logic [7:0] v8, input string nm);
        @(negedge clk);
        a4 = v4;
        a8 = v8;
        push(v4, v8, nm);
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] r4;
        logic [7:0] r8;

        // Reset holds outputs at zero even with a nonzero input.
        rst = 1'b1;
        a4  = 4'h3;
        a8  = 8'h3C;
        #5;
        async_check(4'h0, 8'h00, "reset");
        rst = 1'b0;
        // First capture at the 50 ns edge.
        push(4'h3, 8'h3C, "first_capture");
        @(posedge clk);
        #2;

        // Directed sequence; c must match b on the same edge.
        step(4'h7, 8'h7E, "seq7");
        step(4'hF, 8'hF0, "seqF");
        step(4'hA, 8'h5A, "seqA");
        step(4'h2, 8'h24, "seq2");

        // Mid-cycle change: only the last value before the edge is captured.
        @(negedge clk);
        a4 = 4'h5;
        a8 = 8'h55;
        #20;
        async_check(4'h2, 8'h24, "hold_after_5");
        a4 = 4'h9;
        a8 = 8'h99;
        #5;
        async_check(4'h2, 8'h24, "hold_after_9");
        push(4'h9, 8'h99, "capture9");
        @(posedge clk);
        #2;

        // Full-width copy on the 8-bit instance.
        step(4'hF, 8'hA5, "wide_a5");

        // Async reset at a falling-edge time clears immediately.
        @(negedge clk);
        a4  = 4'h6;
        a8  = 8'h6C;
        rst = 1'b1;
        async_check(4'h0, 8'h00, "async_reset");
        push(4'h0, 8'h00, "reset_hold1");
        @(posedge clk);
        #2;
        push(4'h0, 8'h00, "reset_hold2");
        @(posedge clk);
        #2;
        @(negedge clk);
        rst = 1'b0;
        push(4'h6, 8'h6C, "post_reset");
        @(posedge clk);
        #2;

        // Random inputs: outputs equal the value present at the previous edge.
        for (int i = 0; i < 100; i++) begin
            r4 = 4'($urandom_range(0, 15));
            r8 = 8'($urandom_range(0, 255));
            step(r4, r8, "random");
        end

        #10;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
